// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction-fetch unit: FSM states,
// the idle NOP word and the opcode field position within an op word.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [31:0] NOP_OP        = 32'hE000_0000;
    localparam logic [3:0]  HALT_OPC_DFLT = 4'hF;
    localparam int          OPC_MSB       = 31;
    localparam int          OPC_LSB       = 28;

    function automatic logic [3:0] opcode_of(input logic [31:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/imem_16x32.sv
// Instruction memory: synchronous write, asynchronous read, contents not reset.
// Read data follows raddr combinationally; writes land at the rising edge.
module imem_16x32 #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/sequencer: program counter, run/halt FSM, load port into imem.
// op is imem[pc] with one-cycle step/jump latency; optional INSTR_FETCH_STEP_EN adds a step gate.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int          DEPTH    = 16,
    parameter int          AW       = 4,
    parameter logic [3:0]  HALT_OPC = HALT_OPC_DFLT
) (
    input  logic          clk,
    input  logic          rst,
`ifdef INSTR_FETCH_STEP_EN
    input  logic          step,
`endif
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          start,
    input  logic          pc_we,
    input  logic [AW-1:0] pc_in,
    output logic [31:0]   op,
    output logic          op_valid,
    output logic [AW-1:0] pc,
    output logic          running,
    output logic          halted
);

    state_t        state;
    logic [AW-1:0] pc_q;
    logic [31:0]   rd_word;
    logic          advance;
    logic          mem_we;

`ifdef INSTR_FETCH_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    // The program is frozen while it executes; loads only land in IDLE/HALT.
    assign mem_we = load_we && (state != RUN);

    imem_16x32 #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_imem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc_q),
        .rdata (rd_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc_q  <= '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state <= RUN;
                        pc_q  <= '0;
                    end
                end
                RUN: begin
                    if (advance) begin
                        // A halt opcode outranks a same-cycle jump request.
                        if (opcode_of(rd_word) == HALT_OPC) begin
                            state <= HALT;
                        end else if (pc_we) begin
                            pc_q <= pc_in;
                        end else begin
                            pc_q <= pc_q + AW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    pc_q  <= '0;
                end
            endcase
        end
    end

    assign running  = (state == RUN);
    assign halted   = (state == HALT);
    assign pc       = pc_q;
    assign op       = running ? rd_word : NOP_OP;
`ifdef INSTR_FETCH_STEP_EN
    assign op_valid = running && step;
`else
    assign op_valid = running;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and randomized bench for instr_fetch against an array/integer reference model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_we;
    logic [3:0]  load_addr;
    logic [31:0] load_data;
    logic        start;
    logic        pc_we;
    logic [3:0]  pc_in;
    logic [31:0] op;
    logic        op_valid;
    logic [3:0]  pc;
    logic        running;
    logic        halted;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: program array, pc as integer, state 0=idle 1=run 2=halt
    logic [31:0] m_mem [16];
    int          m_pc = 0;
    int          m_st = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk       (clk),
        .rst       (rst),
`ifdef INSTR_FETCH_STEP_EN
        .step      (1'b1),
`endif
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .pc_we     (pc_we),
        .pc_in     (pc_in),
        .op        (op),
        .op_valid  (op_valid),
        .pc        (pc),
        .running   (running),
        .halted    (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic cyc(input string tag, input bit r, input bit we, input int a,
                       input logic [31:0] d, input bit s, input bit pw, input int pi);
        logic [31:0] e_op;
        rst       = r;
        load_we   = we;
        load_addr = 4'(a);
        load_data = d;
        start     = s;
        pc_we     = pw;
        pc_in     = 4'(pi);
        @(posedge clk);
        if (we && m_st != 1) m_mem[a] = d;
        if (r) begin
            m_st = 0;
            m_pc = 0;
        end else if (m_st != 1) begin
            if (s) begin
                m_st = 1;
                m_pc = 0;
            end
        end else if (m_mem[m_pc][31:28] == 4'hF) begin
            m_st = 2;
        end else begin
            m_pc = pw ? pi : (m_pc + 1) % 16;
        end
        #1;
        e_op = (m_st == 1) ? m_mem[m_pc] : 32'hE000_0000;
        chk({tag, ".op"},       op,            e_op);
        chk({tag, ".pc"},       32'(pc),       32'(m_pc));
        chk({tag, ".op_valid"}, 32'(op_valid), 32'(m_st == 1));
        chk({tag, ".running"},  32'(running),  32'(m_st == 1));
        chk({tag, ".halted"},   32'(halted),   32'(m_st == 2));
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 32'h0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] seq_words [4];
        seq_words[0] = 32'h0100_0000;
        seq_words[1] = 32'h0200_0000;
        seq_words[2] = 32'h0300_0000;
        seq_words[3] = 32'hF000_0000;

        // Reset / idle
        cyc("rst0", 1, 0, 0, 32'h0, 0, 0, 0);
        cyc("rst1", 1, 0, 0, 32'h0, 0, 0, 0);
        chk("rst_pc",       32'(pc),       32'h0);
        chk("rst_op",       op,            32'hE000_0000);
        chk("rst_op_valid", 32'(op_valid), 32'h0);
        chk("rst_running",  32'(running),  32'h0);
        chk("rst_halted",   32'(halted),   32'h0);

        // Sequential run ending in a halt opcode
        for (int i = 0; i < 16; i++)
            cyc("load", 0, 1, i, (i < 4) ? seq_words[i] : 32'(i), 0, 0, 0);
        cyc("seq_start", 0, 0, 0, 32'h0, 1, 0, 0);
        chk("seq_op0", op, 32'h0100_0000);
        idle("seq1");
        chk("seq_op1", op, 32'h0200_0000);
        idle("seq2");
        chk("seq_op2", op, 32'h0300_0000);
        idle("seq3");
        chk("seq_op3", op, 32'hF000_0000);
        idle("seq_halt");
        chk("seq_halted", 32'(halted), 32'h1);
        chk("seq_halt_pc", 32'(pc), 32'h3);

        // Jump: loads accepted in HALT, start restarts from 0
        cyc("jload0", 0, 1, 0, 32'h1000_000A, 0, 0, 0);
        cyc("jload10", 0, 1, 10, 32'h0A00_00AA, 0, 0, 0);
        cyc("jstart", 0, 0, 0, 32'h0, 1, 0, 0);
        chk("jmp_op0", op, 32'h1000_000A);
        cyc("jmp_a", 0, 0, 0, 32'h0, 0, 1, 10);
        chk("jmp_pc10", 32'(pc), 32'd10);
        chk("jmp_op10", op, 32'h0A00_00AA);
        cyc("jmp_5", 0, 0, 0, 32'h0, 0, 1, 5);
        cyc("jmp_0", 0, 0, 0, 32'h0, 0, 1, 0);
        chk("jmp_to_0", 32'(pc), 32'h0);

        // Wrap 15 -> 0 with an all-opcode-0 program
        cyc("wrst", 1, 0, 0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            cyc("wload", 0, 1, i, 32'h0000_0100 | 32'(i), 0, 0, 0);
        cyc("wstart", 0, 0, 0, 32'h0, 1, 0, 0);
        cyc("wjmp", 0, 0, 0, 32'h0, 0, 1, 13);
        idle("w14");
        chk("wrap_14", 32'(pc), 32'd14);
        idle("w15");
        chk("wrap_15", 32'(pc), 32'd15);
        idle("w0");
        chk("wrap_0", 32'(pc), 32'd0);
        idle("w1");
        chk("wrap_1", 32'(pc), 32'd1);
        chk("wrap_not_halted", 32'(halted), 32'h0);

        // Load attempted during RUN must not reach imem
        cyc("blk_load", 0, 1, 2, 32'hF000_0000, 0, 0, 0);
        chk("blk_op2", op, 32'h0000_0102);
        idle("blk_pass");
        chk("blk_pc3", 32'(pc), 32'd3);
        chk("blk_running", 32'(running), 32'h1);

        // Reset in the middle of a run, then restart with the retained program
        cyc("mr_jmp7", 0, 0, 0, 32'h0, 0, 1, 7);
        chk("mr_pc7", 32'(pc), 32'd7);
        cyc("mr_rst", 1, 0, 0, 32'h0, 0, 0, 0);
        chk("mr_pc", 32'(pc), 32'h0);
        chk("mr_op", op, 32'hE000_0000);
        chk("mr_running", 32'(running), 32'h0);
        cyc("mr_start", 0, 0, 0, 32'h0, 1, 0, 0);
        chk("mr_restart_op", op, 32'h0000_0100);
        idle("mr_step");
        chk("mr_restart_pc1", 32'(pc), 32'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            bit r;
            r = ($urandom_range(0, 31) == 0);
            cyc("rand", r, $urandom_range(0, 3) == 0, int'($urandom_range(0, 15)),
                $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                int'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
